jtframe_pocket_dwnld: RTL

Sequences Pocket bridge ROM-data writes into the byte-wide ioctl download stream that feeds the board's SDRAM programming path. 32-bit bridge writes inside a fixed address window are buffered in a small FIFO and serialised into spaced one-cycle ioctl_wr byte strobes. The block drives downloading and owns the start/finish handshake of the download. It sits between the bridge endpoint and the ioctl inputs of the board/ROM-load logic.

---
 rtl/jtframe_pocket_dwnld.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/jtframe_pocket_dwnld.sv
// Buffers Pocket bridge ROM-window writes and replays them as spaced ioctl byte strobes.
// Build option: define JTFRAME_POCKET_DWNLD_LE_EN to emit each word LSB first.
module jtframe_pocket_dwnld #(
  parameter int          AW       = 3,
  parameter logic [31:0] WIN_BASE = 32'h1000_0000,
  parameter int          WIN_AW   = 25,
  parameter int          GAP      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bridge_wr,
  input  logic [31:0]       bridge_addr,
  input  logic [31:0]       bridge_wr_data,
  input  logic              dwnld_start,
  input  logic              dwnld_end,
  output logic [WIN_AW-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_wr,
  output logic              downloading,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int          DEPTH     = 1 << AW;
  localparam int          OW        = WIN_AW - 2;
  localparam int          FW        = OW + 32;
  localparam logic [32:0] WIN_END   = {1'b0, WIN_BASE} + (33'd1 << WIN_AW);
  localparam logic [3:0]  GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BYTE,
    ST_GAP,
    ST_NEXT
  } state_t;

  state_t          state_reg, state_next;
  logic [1:0]      idx_reg, idx_next;
  logic [3:0]      gap_cnt_reg, gap_cnt_next;
  logic [31:0]     word_reg;
  logic [OW-1:0]   off_reg;
  logic            open_reg;
  logic            overflow_reg;
  logic [FW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     count_reg, count_next;
  logic            full_reg;
  logic [WIN_AW-1:0] ioctl_addr_reg;
  logic [7:0]      ioctl_dout_reg;
  logic            ioctl_wr_reg;

  logic            fifo_empty;
  logic            in_window;
  logic            win_hit;
  logic            push;
  logic            pop;
  logic            drop;
  logic            start_ok;
  logic [OW-1:0]   win_off;
  logic [7:0]      lane [4];
  logic [7:0]      byte_sel;

  assign fifo_empty  = (count_reg == '0);
  assign downloading = open_reg | ~fifo_empty | (state_reg != ST_IDLE);

  // Word offset inside the window; bits [1:0] are replaced by the byte index later.
  assign win_off   = bridge_addr[WIN_AW-1:2] - WIN_BASE[WIN_AW-1:2];
  assign in_window = (bridge_addr >= WIN_BASE) && ({1'b0, bridge_addr} < WIN_END);
  assign win_hit   = bridge_wr & downloading & in_window;

  // A full FIFO still takes a word when the FSM pops on the same edge.
  assign push     = win_hit & (~full_reg | pop);
  assign drop     = win_hit & ~push;
  assign start_ok = dwnld_start & ~downloading & ~dwnld_end;

  assign count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_reg[8*gi +: 8];
    end
  endgenerate

`ifdef JTFRAME_POCKET_DWNLD_LE_EN
  assign byte_sel = lane[idx_reg];
`else
  // Big-endian: index 0 is the most significant lane.
  assign byte_sel = lane[~idx_reg];
`endif

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    gap_cnt_next = gap_cnt_reg;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          idx_next   = 2'd0;
          state_next = ST_BYTE;
        end
      end
      ST_BYTE: begin
        gap_cnt_next = 4'd0;
        state_next   = (GAP == 0) ? ST_NEXT : ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_NEXT;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      ST_NEXT: begin
        if (idx_reg == 2'd3) begin
          state_next = ST_IDLE;
        end else begin
          idx_next   = idx_reg + 2'd1;
          state_next = ST_BYTE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Storage array kept free of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {win_off, bridge_wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 2'd0;
      gap_cnt_reg    <= 4'd0;
      word_reg       <= '0;
      off_reg        <= '0;
      open_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      ioctl_addr_reg <= '0;
      ioctl_dout_reg <= '0;
      ioctl_wr_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      gap_cnt_reg <= gap_cnt_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg          <= rd_ptr_reg + AW'(1);
        {off_reg, word_reg} <= mem[rd_ptr_reg];
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);

      // dwnld_end takes priority over a coincident dwnld_start.
      if (dwnld_end) begin
        open_reg <= 1'b0;
      end else if (start_ok) begin
        open_reg <= 1'b1;
      end

      if (start_ok) begin
        overflow_reg <= 1'b0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
      end

      ioctl_wr_reg <= (state_reg == ST_BYTE);
      if (state_reg == ST_BYTE) begin
        ioctl_addr_reg <= {off_reg, idx_reg};
        ioctl_dout_reg <= byte_sel;
      end
    end
  end

  assign ioctl_addr = ioctl_addr_reg;
  assign ioctl_dout = ioctl_dout_reg;
  assign ioctl_wr   = ioctl_wr_reg;
  assign fifo_full  = full_reg;
  assign overflow   = overflow_reg;

endmodule
